// File: rtl/down_counter.sv
// down_counter: loadable countdown timer with optional prescaler.
// Counts from a loaded value (all ones after reset) down to zero, then stops
// in DONE with a sticky finished flag and a one-cycle done pulse.
// All state updates on the falling edge of clockDownCounter; reset is
// asynchronous and active-low.
// Optional feature: define DOWN_COUNTER_RELOAD_EN for periodic mode, where a
// terminal tick reloads the last loaded value instead of entering DONE.
//
// Handshake/control semantics: there is no valid/ready pair. loadDownCounter
// is a level-sampled strobe that wins over every state except reset, and
// enableDownCounter is a level-sampled run/hold control. Both are sampled on
// the falling edge only.
module down_counter #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clockDownCounter,
    input  logic             resetDownCounter,
    input  logic             loadDownCounter,
    input  logic [WIDTH-1:0] loadValueDownCounter,
    input  logic             enableDownCounter,
    output logic [WIDTH-1:0] valueDownCounter,
    output logic             finishedDownCounter,
    output logic             doneDownCounter
);

    // Prescaler counter is exactly wide enough to hold PRESCALE-1.
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic             finished_q, finished_d;
    logic             done_q, done_d;
`ifdef DOWN_COUNTER_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    // Next-state logic: load first, then per-state run/hold/terminal handling.
    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        presc_d    = presc_q;
        finished_d = finished_q;
        done_d     = 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
        reload_d   = reload_q;
`endif
        if (loadDownCounter) begin
            value_d    = loadValueDownCounter;
            presc_d    = '0;
            finished_d = 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload_d   = loadValueDownCounter;
`endif
            state_d    = enableDownCounter ? ST_RUN : ST_IDLE;
            // A zero load has nothing to count: finish on this very edge.
            // This also applies in periodic mode, where zero is no valid period.
            if (loadValueDownCounter == '0) begin
                state_d    = ST_DONE;
                finished_d = 1'b1;
                done_d     = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enableDownCounter) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Enable is looked at before the tick, so dropping it on a
                    // terminal edge parks the counter in HOLD untouched.
                    if (!enableDownCounter) begin
                        state_d = ST_HOLD;
                    end else if (presc_q != PS_LAST) begin
                        presc_d = presc_q + PS_W'(1);
                    end else begin
                        presc_d = '0;
                        if (value_q > WIDTH'(1)) begin
                            value_d = value_q - WIDTH'(1);
                        end else begin
`ifdef DOWN_COUNTER_RELOAD_EN
                            value_d = reload_q;
                            done_d  = 1'b1;
`else
                            value_d    = '0;
                            state_d    = ST_DONE;
                            finished_d = 1'b1;
                            done_d     = 1'b1;
`endif
                        end
                    end
                end
                ST_HOLD: begin
                    // Prescaler phase is kept; no tick on the resume edge.
                    if (enableDownCounter) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    value_d    = '0;
                    finished_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register: falling-edge clock, asynchronous active-low reset.
    always_ff @(negedge clockDownCounter or negedge resetDownCounter) begin
        if (!resetDownCounter) begin
            state_q    <= ST_IDLE;
            value_q    <= ALL_ONES;
            presc_q    <= '0;
            finished_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload_q   <= ALL_ONES;
`endif
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            presc_q    <= presc_d;
            finished_q <= finished_d;
            done_q     <= done_d;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload_q   <= reload_d;
`endif
        end
    end

    assign valueDownCounter    = value_q;
    assign finishedDownCounter = finished_q;
    assign doneDownCounter     = done_q;

endmodule
